// File: rtl/multi_motor_controller_if.sv
// multi_motor_controller_if: 8-bit CPU I/O bus between a bus master and the motor controller
interface multi_motor_controller_if;
  logic [7:0] din;
  logic [7:0] address;
  logic [7:0] dout;
  logic       w_en;
  logic       r_en;
  modport master (output din, address, w_en, r_en, input dout);
  modport slave  (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/multi_motor_controller.sv
// multi_motor_controller: N-channel PWM/H-bridge controller with encoder speed measurement and optional speed loop
module multi_motor_controller #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int NUM_CH = 2,
  parameter int PRESCALE = 125,
  parameter int WINDOW_CYCLES = 1600000,
  parameter int RPM_MULT = 157,
  parameter int RPM_SHIFT = 9,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_motor_controller_if.slave bus,
  input  logic [NUM_CH-1:0]     encoders,
  output logic [NUM_CH-1:0]     pwm,
  output logic [2*NUM_CH-1:0]   motor,
  output logic                  enable
);
  localparam int MW = $clog2(RPM_MULT + 1);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int WW = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;

  logic [PW-1:0]     pre_q, pre_d;
  logic [WW-1:0]     win_q, win_d;
  logic [7:0]        ctr_q, ctr_d, dout_q, dout_d, off, rdata;
  logic              en_q, en_d, tick, strobe;
  logic [NUM_CH-1:0] mode_q, mode_d, stall_q, stall_d, s1_q, s2_q, prev_q, pwm_q, pwm_d, edg, loop_on;
  logic [1:0]        dir_q [NUM_CH], dir_d [NUM_CH];
  logic [6:0]        speed_q [NUM_CH], speed_d [NUM_CH], rpm_q [NUM_CH], rpm_d [NUM_CH], rpm_new [NUM_CH];
  logic [7:0]        cmpr_q [NUM_CH], cmpr_d [NUM_CH], cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic [8+MW-1:0]   prod [NUM_CH], shr [NUM_CH];
  logic signed [8:0] err [NUM_CH], adj [NUM_CH];
  logic signed [9:0] sum [NUM_CH];

  assign bus.dout = dout_q;
  assign pwm = pwm_q;
  assign enable = en_q;

  always_comb begin
    off = bus.address - BASE_ADDRESS;
    tick = pre_q == PW'(PRESCALE - 1);
    strobe = win_q == WW'(WINDOW_CYCLES - 1);
    pre_d = tick ? '0 : pre_q + PW'(1);
    win_d = strobe ? '0 : win_q + WW'(1);
    ctr_d = ctr_q + {7'd0, tick};
    en_d = bus.w_en && off == 8'd0 ? bus.din[0] : en_q;
    mode_d = bus.w_en && off == 8'd0 ? bus.din[NUM_CH:1] : mode_q;
    stall_d = bus.w_en && off == 8'd1 ? stall_q & ~bus.din[NUM_CH-1:0] : stall_q;
    rdata = off == 8'd0 ? 8'({mode_q, en_q}) : off == 8'd1 ? 8'(stall_q) : 8'd0;
    edg = s2_q ^ prev_q;
    loop_on = mode_q & {NUM_CH{en_q}};
    motor = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      prod[i] = (8+MW)'(cnt_q[i]) * (8+MW)'(RPM_MULT);
      shr[i] = prod[i] >> RPM_SHIFT;
      rpm_new[i] = shr[i] > (8+MW)'(127) ? 7'd127 : shr[i][6:0];
      err[i] = $signed({2'b00, speed_q[i]}) - $signed({2'b00, rpm_new[i]});
      adj[i] = err[i] >>> GAIN_SHIFT;
      sum[i] = $signed({2'b00, cmpr_q[i]}) + $signed({adj[i][8], adj[i]});
      dir_d[i] = bus.w_en && off == 8'(2 + 4*i) ? bus.din[1:0] : dir_q[i];
      speed_d[i] = bus.w_en && off == 8'(3 + 4*i) ? bus.din[6:0] : speed_q[i];
      // loop update owns cmpr while closed-loop; bus writes only reach open-loop channels
      cmpr_d[i] = strobe && loop_on[i] ? (sum[i][9] ? 8'd0 : sum[i][8] ? 8'hff : sum[i][7:0])
                : bus.w_en && !mode_q[i] && off == 8'(4 + 4*i) ? bus.din : cmpr_q[i];
      rpm_d[i] = strobe ? rpm_new[i] : rpm_q[i];
      cnt_d[i] = strobe ? {7'd0, edg[i]} : edg[i] && cnt_q[i] != 8'hff ? cnt_q[i] + 8'd1 : cnt_q[i];
      if (strobe && loop_on[i] && speed_q[i] != 7'd0 && cmpr_q[i] == 8'hff && cnt_q[i] == 8'd0)
        stall_d[i] = 1'b1;
      pwm_d[i] = ctr_q < cmpr_q[i];
      motor[2*i +: 2] = dir_q[i];
      rdata = off == 8'(2 + 4*i) ? {6'd0, dir_q[i]} : off == 8'(3 + 4*i) ? {1'b0, speed_q[i]}
            : off == 8'(4 + 4*i) ? cmpr_q[i] : off == 8'(5 + 4*i) ? {1'b0, rpm_q[i]} : rdata;
    end
    dout_d = bus.r_en ? rdata : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      win_q <= '0;
      ctr_q <= '0;
      dout_q <= '0;
      en_q <= 1'b0;
      mode_q <= '0;
      stall_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dir_q[i] <= '0;
        speed_q[i] <= '0;
        cmpr_q[i] <= '0;
        rpm_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pre_q <= pre_d;
      win_q <= win_d;
      ctr_q <= ctr_d;
      dout_q <= dout_d;
      en_q <= en_d;
      mode_q <= mode_d;
      stall_q <= stall_d;
      s1_q <= encoders;
      s2_q <= s1_q;
      prev_q <= s2_q;
      pwm_q <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        dir_q[i] <= dir_d[i];
        speed_q[i] <= speed_d[i];
        cmpr_q[i] <= cmpr_d[i];
        rpm_q[i] <= rpm_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_multi_motor_controller.sv
// tb_multi_motor_controller: table-driven register checks plus directed window/loop sequences on two instances
module tb_multi_motor_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = 8'h00, address = 8'h00;
  logic w_en = 1'b0, r_en = 1'b0;
  logic [1:0] enc_a = 2'b00, enc_b = 2'b00, pwm_a, pwm_b;
  logic [3:0] motor_a, motor_b;
  logic enable_a, enable_b;
  int cyc = 0, nvec = 0, nerr = 0;

  typedef struct { bit w; logic [7:0] a; logic [7:0] d; logic [7:0] e; } vec_t;
  vec_t tbl [$];

  multi_motor_controller_if b0 ();
  multi_motor_controller_if b1 ();
  assign b0.din = din;
  assign b0.address = address;
  assign b0.w_en = w_en;
  assign b0.r_en = r_en;
  assign b1.din = din;
  assign b1.address = address;
  assign b1.w_en = w_en;
  assign b1.r_en = r_en;

  multi_motor_controller #(.BASE_ADDRESS(8'h00), .NUM_CH(2), .PRESCALE(1), .WINDOW_CYCLES(1000),
    .RPM_MULT(157), .RPM_SHIFT(9), .GAIN_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .encoders(enc_a), .pwm(pwm_a), .motor(motor_a), .enable(enable_a));
  multi_motor_controller #(.BASE_ADDRESS(8'h40), .NUM_CH(2), .PRESCALE(1), .WINDOW_CYCLES(1000),
    .RPM_MULT(157), .RPM_SHIFT(9), .GAIN_SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .encoders(enc_b), .pwm(pwm_b), .motor(motor_b), .enable(enable_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic vec_t mk(bit w, logic [7:0] a, logic [7:0] d, logic [7:0] e);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wr_now(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = a >= 8'h40 ? b1.dout : b0.dout;
  endtask

  task automatic rdchk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(name, 32'(v), 32'(exp));
  endtask

  // windows close on the posedges where cyc becomes a multiple of 1000
  task automatic to_strobe;
    do @(negedge clk); while (cyc % 1000 != 0);
  endtask

  task automatic pre_strobe;
    do @(negedge clk); while (cyc % 1000 != 999);
  endtask

  task automatic toggles(input bit b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (b) enc_b[0] = ~enc_b[0];
      else enc_a[0] = ~enc_a[0];
      @(negedge clk);
    end
  endtask

  task automatic pwm_count(input string name, input int exp);
    int hi;
    hi = 0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      hi += int'(pwm_a[0]);
    end
    chk(name, 32'(hi), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: reached %0d vectors, required run completion", nvec);
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("pwm_reset", 32'({pwm_b, pwm_a}), 0);
    chk("motor_reset", 32'({motor_b, motor_a}), 0);
    chk("enable_reset", 32'({enable_b, enable_a}), 0);

    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(1'b0, 8'(k), 8'h00, 8'h00));
      tbl.push_back(mk(1'b0, 8'(8'h40 + k), 8'h00, 8'h00));
    end
    tbl.push_back(mk(1'b0, 8'h0A, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h3F, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h4A, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h00, 8'hF8, 8'h00));
    tbl.push_back(mk(1'b1, 8'h00, 8'h07, 8'h07));
    tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h02, 8'hFF, 8'h03));
    tbl.push_back(mk(1'b1, 8'h06, 8'h02, 8'h02));
    tbl.push_back(mk(1'b1, 8'h03, 8'hFF, 8'h7F));
    tbl.push_back(mk(1'b1, 8'h08, 8'hA5, 8'hA5));
    tbl.push_back(mk(1'b1, 8'h05, 8'h55, 8'h00));
    tbl.push_back(mk(1'b1, 8'h01, 8'hFF, 8'h00));
    tbl.push_back(mk(1'b1, 8'h44, 8'h33, 8'h33));
    tbl.push_back(mk(1'b1, 8'h49, 8'h12, 8'h00));
    foreach (tbl[k]) begin
      if (tbl[k].w) wr(tbl[k].a, tbl[k].d);
      rd(tbl[k].a, v);
      chk($sformatf("vec%0d_addr%02h", k, tbl[k].a), 32'(v), 32'(tbl[k].e));
    end
    chk("motor_dir", 32'(motor_a), 32'h0B);

    rd(8'h08, v);
    address = 8'h02;
    repeat (3) @(negedge clk);
    chk("dout_hold", 32'(b0.dout), 32'hA5);

    wr(8'h04, 8'd64);
    pwm_count("pwm_64", 64);
    wr(8'h04, 8'd0);
    pwm_count("pwm_0", 0);
    wr(8'h04, 8'd255);
    pwm_count("pwm_255", 255);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdchk("cmpr_after_rst", 8'h04, 8'h00);

    to_strobe;
    toggles(1'b0, 100);
    to_strobe;
    rdchk("rpm_100_edges", 8'h05, 8'd30);
    rdchk("rpm_ch1_idle", 8'h09, 8'd0);
    to_strobe;
    rdchk("rpm_no_edges", 8'h05, 8'd0);

    wr(8'h03, 8'd40);
    wr(8'h04, 8'd0);
    wr(8'h00, 8'h03);
    chk("enable_on", 32'(enable_a), 1);
    toggles(1'b0, 100);
    to_strobe;
    rdchk("cl_err_plus10", 8'h04, 8'd10);

    wr(8'h00, 8'h01);
    wr(8'h04, 8'd250);
    wr(8'h03, 8'd127);
    wr(8'h00, 8'h03);
    to_strobe;
    rdchk("cl_sat_255", 8'h04, 8'd255);
    rdchk("no_stall_from_250", 8'h01, 8'h00);

    wr(8'h00, 8'h01);
    wr(8'h04, 8'd5);
    wr(8'h03, 8'd0);
    wr(8'h00, 8'h03);
    toggles(1'b0, 66);
    to_strobe;
    rdchk("cl_sat_0", 8'h04, 8'd0);
    rdchk("rpm_66_edges", 8'h05, 8'd20);

    wr(8'h00, 8'h01);
    wr(8'h04, 8'd255);
    wr(8'h03, 8'd50);
    wr(8'h00, 8'h03);
    to_strobe;
    rdchk("stall_set", 8'h01, 8'h01);
    rdchk("stall_cmpr", 8'h04, 8'd255);
    pre_strobe;
    wr_now(8'h01, 8'h01);
    rdchk("stall_set_wins", 8'h01, 8'h01);
    wr(8'h01, 8'h01);
    rdchk("stall_w1c", 8'h01, 8'h00);
    wr(8'h00, 8'h01);
    rdchk("open_keeps_cmpr", 8'h04, 8'd255);

    wr(8'h04, 8'd100);
    wr(8'h00, 8'h02);
    chk("enable_off", 32'(enable_a), 0);
    to_strobe;
    rdchk("cl_disabled_hold", 8'h04, 8'd100);
    rdchk("cl_disabled_no_stall", 8'h01, 8'h00);

    wr(8'h00, 8'h00);
    pre_strobe;
    wr_now(8'h04, 8'd77);
    rdchk("open_write_on_strobe", 8'h04, 8'd77);

    wr(8'h44, 8'd100);
    wr(8'h43, 8'd40);
    wr(8'h40, 8'h03);
    toggles(1'b1, 100);
    to_strobe;
    rdchk("gain2_err_plus10", 8'h44, 8'd102);
    wr(8'h43, 8'd20);
    toggles(1'b1, 100);
    to_strobe;
    rdchk("gain2_err_minus10", 8'h44, 8'd99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
